// File: rtl/keypad_emulator_if.sv
// keypad_emulator_if: push handshake, matrix strobes/senses and status of the keypad emulator
//  key_valid/key_code : press request from the bench side
//  key_ready          : queue not full
//  col / row          : scanner column strobes in, emulated row senses out
//  busy/key_done/key_err : press activity, end-of-press pulse, bad-code pulse
interface keypad_emulator_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic [2:0] col;
  logic [3:0] row;
  logic       busy;
  logic       key_done;
  logic       key_err;
  modport master (output key_valid, key_code, col, input key_ready, row, busy, key_done, key_err);
  modport slave  (input key_valid, key_code, col, output key_ready, row, busy, key_done, key_err);
endinterface

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x3 keypad matrix model replaying queued presses with make/break bounce
//  clk   : rising-edge clock
//  rst_n : asynchronous active-low reset, flushes the queue and opens the contact
//  kp    : slave side of keypad_emulator_if (push handshake, col in, row out, status pulses)
module keypad_emulator #(
  parameter int HOLD_CYCLES    = 200,
  parameter int BOUNCE_CYCLES  = 8,
  parameter int BOUNCE_TOGGLES = 3,
  parameter int GAP_CYCLES     = 50,
  parameter int FIFO_DEPTH     = 4
) (
  input logic              clk,
  input logic              rst_n,
  keypad_emulator_if.slave kp
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] BNC_DN = 3'd1;
  localparam logic [2:0] HOLD   = 3'd2;
  localparam logic [2:0] BNC_UP = 3'd3;
  localparam logic [2:0] GAP    = 3'd4;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CM1  = HOLD_CYCLES > BOUNCE_CYCLES ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int CMAX = CM1 > GAP_CYCLES ? CM1 : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int PL   = BOUNCE_TOGGLES > 0 ? 2 * BOUNCE_TOGGLES - 1 : 0;
  localparam int PW   = PL > 0 ? $clog2(PL + 1) : 1;
  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] ph;
  logic [1:0]    kr, kc;
  logic          key_done, key_err;
  logic          empty, full, push, code_ok, contact;
  logic [3:0]    head;
  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = kp.key_valid && !full;
  assign code_ok = kp.key_code < 4'd12;
  assign head    = mem[rd_ptr[AW-1:0]];
  // Bounce phases alternate made/open starting made; the last phase of each burst is open.
  assign contact = (state == HOLD) || ((state == BNC_DN || state == BNC_UP) && !ph[0]);
  // Switch-like path: col to row is purely combinational.
  assign kp.row       = (contact && kp.col[kc]) ? 4'(4'd1 << kr) : 4'd0;
  assign kp.key_ready = !full;
  assign kp.busy      = (state != IDLE) || !empty;
  assign kp.key_done  = key_done;
  assign kp.key_err   = key_err;
  always_ff @(posedge clk)
    if (push && code_ok) mem[wr_ptr[AW-1:0]] <= kp.key_code;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      state    <= IDLE;
      cnt      <= '0;
      ph       <= '0;
      kr       <= '0;
      kc       <= '0;
      key_done <= 1'b0;
      key_err  <= 1'b0;
    end else begin
      key_done <= 1'b0;
      key_err  <= push && !code_ok;
      if (push && code_ok) wr_ptr <= wr_ptr + 1'b1;
      case (state)
        IDLE:
          if (!empty) begin
            rd_ptr <= rd_ptr + 1'b1;
            kr     <= 2'(head / 4'd3);
            kc     <= 2'(head % 4'd3);
            cnt    <= '0;
            ph     <= '0;
            state  <= BOUNCE_TOGGLES > 0 ? BNC_DN : HOLD;
          end
        BNC_DN, BNC_UP:
          if (cnt == CW'(BOUNCE_CYCLES - 1)) begin
            cnt <= '0;
            if (ph == PW'(PL)) begin
              ph    <= '0;
              state <= state == BNC_DN ? HOLD : GAP;
            end else ph <= ph + 1'b1;
          end else cnt <= cnt + 1'b1;
        HOLD:
          if (cnt == CW'(HOLD_CYCLES - 1)) begin
            cnt   <= '0;
            state <= BOUNCE_TOGGLES > 0 ? BNC_UP : GAP;
          end else cnt <= cnt + 1'b1;
        GAP:
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            cnt      <= '0;
            state    <= IDLE;
            key_done <= 1'b1;
          end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
